// File: rtl/id_stage.sv
// Instruction-decode stage of the MIPS-Lite pipeline: opcode decode, 32x32 register
// file with write-back bypass, load-use stall detection and the registered ID/EX outputs.
module id_stage #(
  parameter int DATAWIDTH    = 32,
  parameter int ADDRESSWIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDRESSWIDTH-1:0] if_pc,
  input  logic [31:0]             if_instruction,
  input  logic                    if_valid,
  input  logic                    flush,
  input  logic                    wb_we,
  input  logic [4:0]              wb_rd,
  input  logic [DATAWIDTH-1:0]    wb_data,
  output logic                    stall,
  output logic                    id_valid,
  output logic [ADDRESSWIDTH-1:0] id_pc,
  output logic [5:0]              id_opcode,
  output logic [4:0]              id_rs,
  output logic [4:0]              id_rt,
  output logic [4:0]              id_dest,
  output logic [DATAWIDTH-1:0]    id_rs_val,
  output logic [DATAWIDTH-1:0]    id_rt_val,
  output logic [DATAWIDTH-1:0]    id_imm,
  output logic                    id_regwrite,
  output logic                    id_memread,
  output logic                    id_memwrite,
  output logic                    id_branch,
  output logic                    id_halt,
  output logic                    halted
);

  localparam logic [5:0] OP_LAST_ALU = 6'd11;
  localparam logic [5:0] OP_LDW      = 6'd12;
  localparam logic [5:0] OP_STW      = 6'd13;
  localparam logic [5:0] OP_BZ       = 6'd14;
  localparam logic [5:0] OP_BEQ      = 6'd15;
  localparam logic [5:0] OP_JR       = 6'd16;
  localparam logic [5:0] OP_HALT     = 6'd17;

  typedef struct packed {
    logic       legal;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       halt;
    logic       reads_rs;
    logic       reads_rt;
    logic [4:0] dest;
  } dec_t;

  // Instruction fields
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;

  assign op    = if_instruction[31:26];
  assign rs    = if_instruction[25:21];
  assign rt    = if_instruction[20:16];
  assign rd    = if_instruction[15:11];
  assign imm16 = if_instruction[15:0];

  dec_t dec;

  always_comb begin
    dec       = '0;
    dec.legal = (op <= OP_HALT);
    if (op <= OP_LAST_ALU) begin
      dec.regwrite = 1'b1;
      dec.reads_rs = 1'b1;
      if (op[0]) begin
        dec.dest = rt;
      end else begin
        dec.dest     = rd;
        dec.reads_rt = 1'b1;
      end
    end else begin
      unique case (op)
        OP_LDW: begin
          dec.regwrite = 1'b1;
          dec.memread  = 1'b1;
          dec.reads_rs = 1'b1;
          dec.dest     = rt;
        end
        OP_STW: begin
          dec.memwrite = 1'b1;
          dec.reads_rs = 1'b1;
          dec.reads_rt = 1'b1;
        end
        OP_BZ, OP_JR: begin
          dec.branch   = 1'b1;
          dec.reads_rs = 1'b1;
        end
        OP_BEQ: begin
          dec.branch   = 1'b1;
          dec.reads_rs = 1'b1;
          dec.reads_rt = 1'b1;
        end
        OP_HALT: dec.halt = 1'b1;
        default: ;
      endcase
    end
  end

  // Register file; entry 0 is never written and is masked on read.
  logic [DATAWIDTH-1:0] rf_q [32];
  logic                 wb_fire;

  assign wb_fire = wb_we && (wb_rd != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_fire) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  logic [DATAWIDTH-1:0] rs_val;
  logic [DATAWIDTH-1:0] rt_val;

  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != 5'd0) rs_val = (wb_fire && wb_rd == rs) ? wb_data : rf_q[rs];
    if (rt != 5'd0) rt_val = (wb_fire && wb_rd == rt) ? wb_data : rf_q[rt];
  end

  // ID/EX pipeline register
  logic                    valid_q,    valid_d;
  logic [ADDRESSWIDTH-1:0] pc_q,       pc_d;
  logic [5:0]              opcode_q,   opcode_d;
  logic [4:0]              rs_q,       rs_d;
  logic [4:0]              rt_q,       rt_d;
  logic [4:0]              dest_q,     dest_d;
  logic [DATAWIDTH-1:0]    rs_val_q,   rs_val_d;
  logic [DATAWIDTH-1:0]    rt_val_q,   rt_val_d;
  logic [DATAWIDTH-1:0]    imm_q,      imm_d;
  logic                    regwrite_q, regwrite_d;
  logic                    memread_q,  memread_d;
  logic                    memwrite_q, memwrite_d;
  logic                    branch_q,   branch_d;
  logic                    halt_q,     halt_d;
  logic                    halted_q,   halted_d;

  logic eff_valid;
  logic hazard;
  logic issue;

  // Handshake with IF: stall=1 means IF must present the same pc/instruction on the
  // next cycle; whenever stall=0 the if_* pair is consumed at the rising edge.
  // stall is deliberately independent of flush; a flush overrides it inside IF.
  assign eff_valid = if_valid && !halted_q;
  assign hazard    = eff_valid && dec.legal && valid_q && memread_q && (dest_q != 5'd0) &&
                     ((dec.reads_rs && rs == dest_q) || (dec.reads_rt && rt == dest_q));
  assign stall     = halted_q || hazard;
  assign issue     = eff_valid && dec.legal && !hazard && !flush;

  always_comb begin
    valid_d    = issue;
    pc_d       = if_pc;
    opcode_d   = op;
    rs_d       = rs;
    rt_d       = rt;
    dest_d     = dec.dest;
    rs_val_d   = rs_val;
    rt_val_d   = rt_val;
    imm_d      = {{(DATAWIDTH-16){imm16[15]}}, imm16};
    regwrite_d = issue && dec.regwrite;
    memread_d  = issue && dec.memread;
    memwrite_d = issue && dec.memwrite;
    branch_d   = issue && dec.branch;
    halt_d     = issue && dec.halt;
    halted_d   = halted_q || (issue && dec.halt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      opcode_q   <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      dest_q     <= '0;
      rs_val_q   <= '0;
      rt_val_q   <= '0;
      imm_q      <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      branch_q   <= 1'b0;
      halt_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      dest_q     <= dest_d;
      rs_val_q   <= rs_val_d;
      rt_val_q   <= rt_val_d;
      imm_q      <= imm_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      branch_q   <= branch_d;
      halt_q     <= halt_d;
      halted_q   <= halted_d;
    end
  end

  assign id_valid    = valid_q;
  assign id_pc       = pc_q;
  assign id_opcode   = opcode_q;
  assign id_rs       = rs_q;
  assign id_rt       = rt_q;
  assign id_dest     = dest_q;
  assign id_rs_val   = rs_val_q;
  assign id_rt_val   = rt_val_q;
  assign id_imm      = imm_q;
  assign id_regwrite = regwrite_q;
  assign id_memread  = memread_q;
  assign id_memwrite = memwrite_q;
  assign id_branch   = branch_q;
  assign id_halt     = halt_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: decode vector table through an expected-result queue, plus
// hand sequences for bypass, load-use stall, flush, halt and asynchronous reset.
module tb_id_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        if_valid;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic [31:0] id_rs_val, id_rt_val, id_imm;
  logic        id_regwrite, id_memread, id_memwrite, id_branch, id_halt;
  logic        halted;

  id_stage #(.DATAWIDTH(32), .ADDRESSWIDTH(32)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_instruction(if_instruction),
    .if_valid(if_valid), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest), .id_rs_val(id_rs_val),
    .id_rt_val(id_rt_val), .id_imm(id_imm), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
    .id_halt(id_halt), .halted(halted)
  );

  logic [4:0] ctrl;
  assign ctrl = {id_regwrite, id_memread, id_memwrite, id_branch, id_halt};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  ctrl;
    logic [31:0] rsv;
    logic [31:0] rtv;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic [31:0] instr;
    logic        vld;
    logic        exp_valid;
    logic [4:0]  exp_dest;
    logic [31:0] exp_imm;
    logic [4:0]  exp_ctrl;
    logic [31:0] exp_rsv;
    logic [31:0] exp_rtv;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input int op, input int rs, input int rt, input int rd);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'b0};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic vld);
    if_pc          = pc;
    if_instruction = instr;
    if_valid       = vld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_out(input exp_t e, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    check({t, "_valid"}, id_valid, e.valid);
    check({t, "_ctrl"}, ctrl, e.ctrl);
    if (e.valid) begin
      check({t, "_pc"}, id_pc, e.pc);
      check({t, "_op"}, id_opcode, e.op);
      check({t, "_rs"}, id_rs, e.rs);
      check({t, "_rt"}, id_rt, e.rt);
      check({t, "_dest"}, id_dest, e.dest);
      check({t, "_imm"}, id_imm, e.imm);
      check({t, "_rsval"}, id_rs_val, e.rsv);
      check({t, "_rtval"}, id_rt_val, e.rtv);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    exp_t e;
    // Registers r1..r7 are preloaded with 0x11*n before the table runs.
    vecs[0]  = '{r_ins(0, 1, 2, 4),          1'b1, 1'b1, 5'd4, 32'h0000_2000, 5'b10000, 32'h11, 32'h22};
    vecs[1]  = '{i_ins(3, 1, 1, 16'hFFFC),   1'b1, 1'b1, 5'd1, 32'hFFFF_FFFC, 5'b10000, 32'h11, 32'h11};
    vecs[2]  = '{i_ins(12, 5, 6, 8),         1'b1, 1'b1, 5'd6, 32'h0000_0008, 5'b11000, 32'h55, 32'h66};
    vecs[3]  = '{i_ins(13, 2, 3, 4),         1'b1, 1'b1, 5'd0, 32'h0000_0004, 5'b00100, 32'h22, 32'h33};
    vecs[4]  = '{i_ins(15, 1, 2, 16'hFFFE),  1'b1, 1'b1, 5'd0, 32'hFFFF_FFFE, 5'b00010, 32'h11, 32'h22};
    vecs[5]  = '{i_ins(14, 7, 0, 16'h0010),  1'b1, 1'b1, 5'd0, 32'h0000_0010, 5'b00010, 32'h77, 32'h0};
    vecs[6]  = '{i_ins(16, 5, 0, 0),         1'b1, 1'b1, 5'd0, 32'h0000_0000, 5'b00010, 32'h55, 32'h0};
    vecs[7]  = '{i_ins(11, 3, 7, 16'h00FF),  1'b1, 1'b1, 5'd7, 32'h0000_00FF, 5'b10000, 32'h33, 32'h77};
    vecs[8]  = '{r_ins(4, 6, 7, 1),          1'b1, 1'b1, 5'd1, 32'h0000_0800, 5'b10000, 32'h66, 32'h77};
    vecs[9]  = '{32'hFC00_0000,              1'b1, 1'b0, 5'd0, 32'h0,         5'b00000, 32'h0,  32'h0};
    vecs[10] = '{r_ins(18, 1, 2, 3),         1'b1, 1'b0, 5'd0, 32'h0,         5'b00000, 32'h0,  32'h0};
    vecs[11] = '{r_ins(0, 1, 2, 3),          1'b0, 1'b0, 5'd0, 32'h0,         5'b00000, 32'h0,  32'h0};
    vecs[12] = '{r_ins(8, 0, 0, 2),          1'b1, 1'b1, 5'd2, 32'h0000_1000, 5'b10000, 32'h0,  32'h0};
    vecs[13] = '{i_ins(12, 1, 0, 4),         1'b1, 1'b1, 5'd0, 32'h0000_0004, 5'b11000, 32'h11, 32'h0};
    vecs[14] = '{r_ins(0, 0, 0, 3),          1'b1, 1'b1, 5'd3, 32'h0000_1800, 5'b10000, 32'h0,  32'h0};

    // Reset with a valid HALT on the input: nothing may leak through.
    reset = 1'b1;
    flush = 1'b0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    drive(32'h0, 32'h4400_0000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", id_valid, 1'b0);
    check("rst_pc", id_pc, 32'h0);
    check("rst_ctrl", ctrl, 5'b0);
    check("rst_imm", id_imm, 32'h0);
    check("rst_halted", halted, 1'b0);
    check("rst_stall", stall, 1'b0);

    // ADDI r1,r0,5 right after reset.
    reset = 1'b0;
    drive(32'h100, 32'h0401_0005, 1'b1);
    tick();
    check("addi_valid", id_valid, 1'b1);
    check("addi_dest", id_dest, 5'd1);
    check("addi_imm", id_imm, 32'd5);
    check("addi_ctrl", ctrl, 5'b10000);
    check("addi_rsval", id_rs_val, 32'h0);

    // Preload r1..r7 through write-back.
    drive(32'h0, 32'h0, 1'b0);
    for (int r = 1; r <= 7; r++) begin
      wb_we = 1'b1; wb_rd = 5'(r); wb_data = 32'h11 * r;
      tick();
    end
    wb_we = 1'b0;

    // Decode table through the expected queue.
    for (int i = 0; i < NV; i++) begin
      drive(32'h1000 + 32'(i * 4), vecs[i].instr, vecs[i].vld);
      e.valid = vecs[i].exp_valid;
      e.op    = vecs[i].instr[31:26];
      e.rs    = vecs[i].instr[25:21];
      e.rt    = vecs[i].instr[20:16];
      e.dest  = vecs[i].exp_dest;
      e.pc    = 32'h1000 + 32'(i * 4);
      e.imm   = vecs[i].exp_imm;
      e.ctrl  = vecs[i].exp_ctrl;
      e.rsv   = vecs[i].exp_rsv;
      e.rtv   = vecs[i].exp_rtv;
      exp_q.push_back(e);
      #1;
      check($sformatf("vec%0d_stall", i), stall, 1'b0);
      tick();
      compare_out(exp_q.pop_front(), i);
    end

    // Write-back bypass on r3, then persistence, then r0 never bypassed.
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD;
    drive(32'h2000, r_ins(0, 3, 3, 4), 1'b1);
    tick();
    check("byp_rsval", id_rs_val, 32'hDEAD);
    check("byp_rtval", id_rt_val, 32'hDEAD);
    wb_we = 1'b0;
    drive(32'h2004, r_ins(6, 3, 0, 5), 1'b1);
    tick();
    check("byp_persist", id_rs_val, 32'hDEAD);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hBEEF;
    drive(32'h2008, r_ins(0, 0, 0, 1), 1'b1);
    tick();
    check("byp_r0", id_rs_val, 32'h0);
    wb_we = 1'b0;

    // Load-use: LDW r2,0(r1) then ADD r5,r2,r6 -> one stall cycle.
    drive(32'h3000, i_ins(12, 1, 2, 0), 1'b1);
    tick();
    drive(32'h3004, r_ins(0, 2, 6, 5), 1'b1);
    #1;
    check("lu_stall", stall, 1'b1);
    tick();
    check("lu_bubble_valid", id_valid, 1'b0);
    check("lu_bubble_ctrl", ctrl, 5'b0);
    check("lu_stall_release", stall, 1'b0);
    tick();
    check("lu_issue_valid", id_valid, 1'b1);
    check("lu_issue_rs", id_rs, 5'd2);
    check("lu_issue_pc", id_pc, 32'h3004);
    check("lu_issue_rsval", id_rs_val, 32'h22);

    // LDW r2 then ADDI r2,r7,1: rt is a destination, not a source.
    drive(32'h3008, i_ins(12, 1, 2, 0), 1'b1);
    tick();
    drive(32'h300C, i_ins(1, 7, 2, 1), 1'b1);
    #1;
    check("lu_itype_nostall", stall, 1'b0);
    tick();
    check("lu_itype_valid", id_valid, 1'b1);
    check("lu_itype_rsval", id_rs_val, 32'h77);

    // Back-to-back loads: LDW r3 then LDW r4,0(r3).
    drive(32'h3010, i_ins(12, 1, 3, 0), 1'b1);
    tick();
    drive(32'h3014, i_ins(12, 3, 4, 0), 1'b1);
    #1;
    check("b2b_stall", stall, 1'b1);
    tick();
    check("b2b_bubble", id_valid, 1'b0);
    check("b2b_release", stall, 1'b0);
    tick();
    check("b2b_issue", ctrl, 5'b11000);
    check("b2b_dest", id_dest, 5'd4);

    // Flush during a pending hazard on r4.
    drive(32'h3018, r_ins(0, 4, 6, 5), 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid", id_valid, 1'b0);
    check("fl_ctrl", ctrl, 5'b0);
    check("fl_stall", stall, 1'b0);
    tick();
    check("fl_next_valid", id_valid, 1'b1);
    check("fl_next_rs", id_rs, 5'd4);

    // HALT, then later instructions are dropped and stall holds.
    drive(32'h4000, 32'h4400_0000, 1'b1);
    tick();
    check("halt_valid", id_valid, 1'b1);
    check("halt_ctrl", ctrl, 5'b00001);
    check("halt_sticky", halted, 1'b1);
    drive(32'h4004, r_ins(0, 1, 2, 4), 1'b1);
    #1;
    check("halt_stall", stall, 1'b1);
    tick();
    check("halt_drop_valid", id_valid, 1'b0);
    check("halt_drop_ctrl", ctrl, 5'b0);
    check("halt_still", halted, 1'b1);
    check("halt_stall_hold", stall, 1'b1);

    // Asynchronous reset mid-cycle while halted.
    #2;
    reset = 1'b1;
    #1;
    check("arst_halted", halted, 1'b0);
    check("arst_valid", id_valid, 1'b0);
    check("arst_pc", id_pc, 32'h0);
    check("arst_stall", stall, 1'b0);
    reset = 1'b0;
    tick();
    check("post_rst_valid", id_valid, 1'b1);
    check("post_rst_dest", id_dest, 5'd4);
    check("post_rst_rsval", id_rs_val, 32'h0);
    check("post_rst_rtval", id_rt_val, 32'h0);
    drive(32'h4008, r_ins(6, 3, 0, 5), 1'b1);
    tick();
    check("post_rst_r3", id_rs_val, 32'h0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
